alu_operand_ctrl: RTL and testbench
===================================

# alu_operand_ctrl

Operand register and execute controller on the upstream side of `opermux`. It debounces the execute button, captures the switch operand and opcode, and drives the A and B operand registers and the `Sel` code into `opermux`. It writes the mux result back into A, and holds a registered copy of the result for the LEDs and the seven-segment driver.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples needed to change the debounced level (10 ms at 100 MHz). Benches use 4.
- `CNT_W`, default 20: debounce counter width. It must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1: system clock, single domain.
- `rst_n`  in  1: synchronous, active-low reset. Top drives it as `~btnU`.
- `btnC`  in  1: raw execute button, asynchronous and bouncy.
- `sw`  in  16: `sw[3:0]` is the opcode and `sw[15:8]` is the 8-bit data input. `sw[7:4]` is ignored.
- `y_in`  in  8: result from `opermux` `Y`.
- `sel`  out  4: latched opcode, drives `opermux` `Sel`.
- `a`  out  8: operand register A.
- `b`  out  8: operand register B.
- `y_q`  out  8: last captured result.
- `led`  out  16: equals {a, b}.
- `done`  out  1: one-cycle pulse in the EXEC cycle.

## Operation
Opcodes, from the shared package:
- ADD 0, SUB 1, SHL 2, SHR 3, CMP 4, AND 5, OR 6, XOR 7, NAND 8, NOR 9, XNOR 10, INV 11, NEG 12, STO 13, SWP 14, LOAD 15.

Input path:
- `btnC` passes through a 2-flop synchronizer into `btn_s`.
- The debouncer counts cycles where `btn_s` differs from `db`. The count clears on any cycle where they are equal.
- When the count reaches DEBOUNCE_CYCLES, `db` toggles and the count clears.
- `press` = `db` rising, i.e. `db` is 1 and the previous `db` was 0.

FSM states are IDLE, LATCH, EXEC and HOLD:
- IDLE: on `press`, go to LATCH.
- LATCH: `sel` <= `sw[3:0]` and `din_q` <= `sw[15:8]`. Go to EXEC. `y_in` then settles against the new `sel`.
- EXEC: `done` = 1 and registers update according to `sel` (below). Go to HOLD.
- HOLD: wait for `db` = 0, then go to IDLE. This gives one operation per press, regardless of hold time.

Register update in EXEC:
- Opcodes 0–12: A <= `y_in`, B unchanged, `y_q` <= `y_in`.
- STO: B <= A, `y_q` <= A.
- SWP: A <= B, B <= A (simultaneous), `y_q` <= B.
- LOAD: A <= `din_q`, B <= A (old A pushes down), `y_q` <= `din_q`.

Width and boundary rules:
- All datapath values are 8-bit unsigned. Results truncate to 8 bits and no carry or flag is kept.
- `sw` changes outside LATCH have no effect.
- A `press` arriving in LATCH, EXEC or HOLD is ignored.

## Timing
Reset (`rst_n` low at a clock edge):
- `a`, `b`, `y_q`, `sel` and `din_q` become 0. The debounce counter becomes 0. `done` = 0.
- Both synchronizer flops reset to 1.
- `db` resets to 1 and the FSM resets to HOLD. A button held through reset therefore never triggers.
- Arming requires the release to debounce. With the button up, `db` falls DEBOUNCE_CYCLES+2 cycles after reset deasserts, and the FSM reaches IDLE one cycle later.
- Reset mid-operation (in LATCH or EXEC) aborts with no register write.

Latency:
- From a `btnC` edge, `db` changes 2 (synchronizer) + DEBOUNCE_CYCLES cycles later.
- `press` is seen in IDLE at cycle P. LATCH is at P+1, EXEC (with `done` high) at P+2, and the new `a`/`b`/`y_q` are visible at P+3.

Glitch rejection: a glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes `db`.

## Structure
- Package `alu_pkg`:
  - the 4-bit opcode localparams listed above;
  - the FSM state encoding;
  - `DATA_W` = 8.
- `opermux` imports the same opcodes.
- One sub-module, `btn_debounce`: synchronizer, counter and level output, parameterized by DEBOUNCE_CYCLES and CNT_W.
- The edge detect and the FSM remain in `alu_operand_ctrl`.
- The bench instantiates the real `opermux` as the `y_in` source.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and the real `opermux`.
- Reset then idle: `rst_n` is low for 3 cycles with `btnC` = 0. Required: `a`/`b`/`y_q`/`sel` = 0, and the FSM reaches IDLE exactly 7 cycles after `rst_n` rises.
- Two loads: set `sw[15:8]` = 0x05 with opcode 15 and press/release, then 0x03 with opcode 15 and press/release. Required: `a` = 0x03, `b` = 0x05, `led` = 0x0305, and exactly 2 `done` pulses.
- ADD with wrap: load 0xFF then 0x01, then opcode 0 and press. Required: `a` = 0x00, `b` = 0xFF, `y_q` = 0x00. Separately, 0x03 + 0x05 gives `a` = 0x08.
- SWP and STO: from `a` = 0x03 and `b` = 0x05, opcode 14 gives `a` = 0x05, `b` = 0x03. Opcode 13 then gives `b` = 0x05 with `a` unchanged.
- Bounce and hold:
  - `btnC` pulses of 1–3 cycles: no `done`.
  - `btnC` held for 50 cycles: exactly one `done`, at 2 + 4 + 2 cycles after the rise.
  - Changing `sw` during HOLD: no register change.
- Reset mid-operation and held button: assert `rst_n` low in LATCH with `btnC` held. Required: registers stay 0, and no `done` until `btnC` is released, debounced and pressed again.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, controller state encoding and datapath width for the
// operand controller and opermux.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_SHL  = 4'd2;
   localparam logic [OP_W-1:0] OP_SHR  = 4'd3;
   localparam logic [OP_W-1:0] OP_CMP  = 4'd4;
   localparam logic [OP_W-1:0] OP_AND  = 4'd5;
   localparam logic [OP_W-1:0] OP_OR   = 4'd6;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
   localparam logic [OP_W-1:0] OP_NAND = 4'd8;
   localparam logic [OP_W-1:0] OP_NOR  = 4'd9;
   localparam logic [OP_W-1:0] OP_XNOR = 4'd10;
   localparam logic [OP_W-1:0] OP_INV  = 4'd11;
   localparam logic [OP_W-1:0] OP_NEG  = 4'd12;
   localparam logic [OP_W-1:0] OP_STO  = 4'd13;
   localparam logic [OP_W-1:0] OP_SWP  = 4'd14;
   localparam logic [OP_W-1:0] OP_LOAD = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   // Opcodes whose result comes from opermux and is written back into A.
   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      return op <= OP_NEG;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer plus stability counter; level changes 2 + DEBOUNCE_CYCLES
// cycles after a clean input edge. Reset level is 1 so a held button stays inert.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level
);

   logic             sync1_q, sync1_d;
   logic             btn_s_q, btn_s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;

   always_comb begin
      sync1_d = btn_raw;
      btn_s_d = sync1_q;
      db_d    = db_q;
      cnt_d   = '0;
      // Any cycle where the input agrees with the level restarts the count.
      if (btn_s_q != db_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = ~db_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         btn_s_q <= 1'b1;
         cnt_q   <= '0;
         db_q    <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         btn_s_q <= btn_s_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
      end
   end

   assign level = db_q;

endmodule

// File: rtl/opermux.sv
// Combinational operation mux: Y = f(A, B) selected by Sel; zero latency.
// Register-move opcodes (STO/SWP/LOAD) are handled upstream; Y passes A for them.
module opermux
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [OP_W-1:0]   Sel,
   output logic [DATA_W-1:0] Y
);

   always_comb begin
      Y = A;
      case (Sel)
         OP_ADD:  Y = A + B;
         OP_SUB:  Y = A - B;
         OP_SHL:  Y = {A[DATA_W-2:0], 1'b0};
         OP_SHR:  Y = {1'b0, A[DATA_W-1:1]};
         // Three-way compare: 0 equal, 1 greater, all-ones less.
         OP_CMP: begin
            if (A == B)     Y = '0;
            else if (A > B) Y = DATA_W'(1);
            else            Y = '1;
         end
         OP_AND:  Y = A & B;
         OP_OR:   Y = A | B;
         OP_XOR:  Y = A ^ B;
         OP_NAND: Y = ~(A & B);
         OP_NOR:  Y = ~(A | B);
         OP_XNOR: Y = ~(A ^ B);
         OP_INV:  Y = ~A;
         OP_NEG:  Y = ~A + DATA_W'(1);
         OP_STO, OP_SWP, OP_LOAD: Y = A;
         default: Y = A;
      endcase
   end

endmodule

// File: rtl/alu_operand_ctrl.sv
// Operand registers and execute FSM feeding opermux; one operation per debounced
// press, results visible 3 cycles after the press is seen in IDLE.
module alu_operand_ctrl
   import alu_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btnC,
   input  logic [15:0]       sw,
   input  logic [DATA_W-1:0] y_in,
   output logic [OP_W-1:0]   sel,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y_q,
   output logic [15:0]       led,
   output logic              done
);

   logic              db;
   logic              db_prev_q, db_prev_d;
   logic              press;
   state_e            state_q, state_d;
   logic [OP_W-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] y_d;
   logic              sw_unused;

   assign sw_unused = ^sw[7:4];

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_raw(btnC),
      .level  (db)
   );

   assign db_prev_d = db;
   assign press     = db & ~db_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_HOLD;
         db_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         db_prev_q <= db_prev_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (press) state_d = ST_LATCH;
         ST_LATCH: state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_HOLD;
         ST_HOLD:  if (!db) state_d = ST_IDLE;
         default:  state_d = ST_HOLD;
      endcase
   end

   always_comb begin
      done = (state_q == ST_EXEC);
   end

   always_comb begin
      sel_d = sel_q;
      din_d = din_q;
      a_d   = a_q;
      b_d   = b_q;
      y_d   = y_q;
      if (state_q == ST_LATCH) begin
         sel_d = sw[3:0];
         din_d = sw[15:8];
      end
      // y_in has had the whole LATCH->EXEC cycle to settle against sel_q.
      if (state_q == ST_EXEC) begin
         if (is_alu_op(sel_q)) begin
            a_d = y_in;
            y_d = y_in;
         end else begin
            case (sel_q)
               OP_STO: begin
                  b_d = a_q;
                  y_d = a_q;
               end
               OP_SWP: begin
                  a_d = b_q;
                  b_d = a_q;
                  y_d = b_q;
               end
               OP_LOAD: begin
                  a_d = din_q;
                  b_d = a_q;
                  y_d = din_q;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q <= '0;
         din_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         y_q   <= '0;
      end else begin
         sel_q <= sel_d;
         din_q <= din_d;
         a_q   <= a_d;
         b_q   <= b_d;
         y_q   <= y_d;
      end
   end

   assign sel = sel_q;
   assign a   = a_q;
   assign b   = b_q;
   assign led = {a_q, b_q};

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Bench for alu_operand_ctrl driving the real opermux, with a register-level
// reference model of the operand stack and opcode arithmetic.
module tb_alu_operand_ctrl;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        btnC;
   logic [15:0] sw;
   logic [7:0]  y_in;
   logic [3:0]  sel;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [7:0]  y_q;
   logic [15:0] led;
   logic        done;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   int ref_a = 0;
   int ref_b = 0;
   int ref_y = 0;

   alu_operand_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .btnC(btnC), .sw(sw), .y_in(y_in),
      .sel(sel), .a(a), .b(b), .y_q(y_q), .led(led), .done(done)
   );

   opermux u_mux (.A(a), .B(b), .Sel(sel), .Y(y_in));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         done_cnt      <= done_cnt + 1;
         last_done_cyc <= cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ref_mux(input int op, input int x, input int y);
      case (op)
         0:  return (x + y) % 256;
         1:  return (x - y + 256) % 256;
         2:  return (x * 2) % 256;
         3:  return x / 2;
         4:  return (x == y) ? 0 : ((x > y) ? 1 : 255);
         5:  return x & y;
         6:  return x | y;
         7:  return x ^ y;
         8:  return 255 - (x & y);
         9:  return 255 - (x | y);
         10: return 255 - (x ^ y);
         11: return 255 - x;
         12: return (256 - x) % 256;
         default: return x;
      endcase
   endfunction

   task automatic model_apply(input int op, input int din);
      int t;
      if (op <= 12) begin
         ref_a = ref_mux(op, ref_a, ref_b);
         ref_y = ref_a;
      end else if (op == 13) begin
         ref_b = ref_a;
         ref_y = ref_a;
      end else if (op == 14) begin
         t = ref_a;
         ref_a = ref_b;
         ref_b = t;
         ref_y = ref_a;
      end else begin
         ref_b = ref_a;
         ref_a = din;
         ref_y = din;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (dut.state_q == ST_IDLE) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s idle_timeout: controller not idle after %0d cycles", tag, budget);
      end
   endtask

   // Press, hold briefly, release; then compare registers with the model.
   task automatic do_op(input int op, input int din, input string tag);
      int  start;
      bit  got;
      start = done_cnt;
      sw    = {din[7:0], 4'($urandom_range(0, 15)), op[3:0]};
      btnC  = 1'b1;
      got   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done_cnt != start) begin
            got = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL %s done_timeout: no done within 40 cycles", tag);
      end
      repeat (3) tick();
      btnC = 1'b0;
      wait_idle(40, tag);
      model_apply(op, din);
      n_vec++;
      if (a !== 8'(ref_a)) begin
         n_err++;
         $display("FAIL %s a: got %02h want %02h", tag, a, 8'(ref_a));
      end
      n_vec++;
      if (b !== 8'(ref_b)) begin
         n_err++;
         $display("FAIL %s b: got %02h want %02h", tag, b, 8'(ref_b));
      end
      n_vec++;
      if (y_q !== 8'(ref_y)) begin
         n_err++;
         $display("FAIL %s y_q: got %02h want %02h", tag, y_q, 8'(ref_y));
      end
      n_vec++;
      if (sel !== op[3:0]) begin
         n_err++;
         $display("FAIL %s sel: got %0d want %0d", tag, sel, op);
      end
      n_vec++;
      if (led !== {8'(ref_a), 8'(ref_b)}) begin
         n_err++;
         $display("FAIL %s led: got %04h want %02h%02h", tag, led, 8'(ref_a), 8'(ref_b));
      end
      n_vec++;
      if (done_cnt - start !== 1) begin
         n_err++;
         $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt - start);
      end
   endtask

   task automatic apply_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) tick();
      rst_n = 1'b1;
      ref_a = 0;
      ref_b = 0;
      ref_y = 0;
   endtask

   task automatic test_reset();
      int k;
      btnC  = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({a, b, y_q, sel} !== 28'h0) begin
         n_err++;
         $display("FAIL reset regs: got a=%02h b=%02h y=%02h sel=%0h want all 0", a, b, y_q, sel);
      end
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL reset done: got %b want 0", done);
      end
      rst_n = 1'b1;
      k = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (dut.state_q == ST_IDLE) begin
            k = i;
            break;
         end
      end
      n_vec++;
      if (k != 7) begin
         n_err++;
         $display("FAIL reset arm_latency: idle after %0d cycles want 7", k);
      end
      ref_a = 0;
      ref_b = 0;
      ref_y = 0;
   endtask

   task automatic test_two_loads();
      int start;
      start = done_cnt;
      do_op(15, 8'h05, "load1");
      do_op(15, 8'h03, "load2");
      n_vec++;
      if (led !== 16'h0305) begin
         n_err++;
         $display("FAIL two_loads led: got %04h want 0305", led);
      end
      n_vec++;
      if (done_cnt - start != 2) begin
         n_err++;
         $display("FAIL two_loads done_count: got %0d want 2", done_cnt - start);
      end
   endtask

   task automatic test_add_wrap();
      do_op(15, 8'hFF, "wrap_ld1");
      do_op(15, 8'h01, "wrap_ld2");
      do_op(0, int'($urandom_range(0, 255)), "wrap_add");
      n_vec++;
      if ({a, b, y_q} !== 24'h00FF00) begin
         n_err++;
         $display("FAIL add_wrap: got a=%02h b=%02h y=%02h want a=00 b=ff y=00", a, b, y_q);
      end
      do_op(15, 8'h05, "add_ld1");
      do_op(15, 8'h03, "add_ld2");
      do_op(0, 0, "add");
      n_vec++;
      if (a !== 8'h08) begin
         n_err++;
         $display("FAIL add_3_5: got a=%02h want 08", a);
      end
   endtask

   task automatic test_swp_sto();
      do_op(15, 8'h05, "swp_ld1");
      do_op(15, 8'h03, "swp_ld2");
      do_op(14, 0, "swp");
      n_vec++;
      if ({a, b} !== 16'h0503) begin
         n_err++;
         $display("FAIL swp: got a=%02h b=%02h want a=05 b=03", a, b);
      end
      do_op(13, 0, "sto");
      n_vec++;
      if ({a, b} !== 16'h0505) begin
         n_err++;
         $display("FAIL sto: got a=%02h b=%02h want a=05 b=05", a, b);
      end
   endtask

   task automatic test_random_ops();
      for (int i = 0; i < 40; i++) begin
         do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), "rand");
      end
   endtask

   task automatic test_bounce();
      int start;
      for (int w = 1; w <= 3; w++) begin
         start = done_cnt;
         btnC  = 1'b1;
         repeat (w) tick();
         btnC = 1'b0;
         repeat (14) tick();
         n_vec++;
         if (done_cnt != start) begin
            n_err++;
            $display("FAIL bounce_%0d: got %0d done pulses want 0", w, done_cnt - start);
         end
         n_vec++;
         if ({a, b} !== {8'(ref_a), 8'(ref_b)}) begin
            n_err++;
            $display("FAIL bounce_%0d regs: got %02h%02h want %02h%02h", w, a, b, 8'(ref_a), 8'(ref_b));
         end
      end
   endtask

   task automatic test_hold();
      int start;
      int rise;
      int op;
      int din;
      op    = int'($urandom_range(0, 15));
      din   = int'($urandom_range(0, 255));
      start = done_cnt;
      sw    = {din[7:0], 4'h0, op[3:0]};
      tick();
      rise = cyc;
      btnC = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done_cnt != start) sw = 16'($urandom);
      end
      btnC = 1'b0;
      wait_idle(40, "hold");
      model_apply(op, din);
      n_vec++;
      if (done_cnt - start != 1) begin
         n_err++;
         $display("FAIL hold done_count: got %0d want 1", done_cnt - start);
      end
      n_vec++;
      if (last_done_cyc - rise != 8) begin
         n_err++;
         $display("FAIL hold done_latency: got %0d want 8", last_done_cyc - rise);
      end
      n_vec++;
      if ({a, b, y_q} !== {8'(ref_a), 8'(ref_b), 8'(ref_y)}) begin
         n_err++;
         $display("FAIL hold regs: got %02h %02h %02h want %02h %02h %02h",
                  a, b, y_q, 8'(ref_a), 8'(ref_b), 8'(ref_y));
      end
   endtask

   task automatic test_reset_mid();
      int  start;
      bit  hit;
      do_op(15, 8'h77, "mid_pre");
      sw   = 16'hAA0F;
      btnC = 1'b1;
      hit  = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (dut.state_q == ST_LATCH) begin
            hit = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!hit) begin
         n_err++;
         $display("FAIL reset_mid latch_timeout: LATCH not reached");
      end
      apply_reset(3);
      start = done_cnt;
      repeat (30) tick();
      n_vec++;
      if (done_cnt != start) begin
         n_err++;
         $display("FAIL reset_mid held_done: got %0d pulses want 0", done_cnt - start);
      end
      n_vec++;
      if ({a, b, y_q, sel} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_mid regs: got a=%02h b=%02h y=%02h sel=%0h want 0", a, b, y_q, sel);
      end
      btnC = 1'b0;
      wait_idle(40, "reset_mid");
      do_op(15, 8'h5A, "reset_mid_load");
   endtask

   initial begin
      rst_n = 1'b0;
      btnC  = 1'b0;
      sw    = 16'h0000;
      test_reset();
      test_two_loads();
      test_add_wrap();
      test_swp_sto();
      test_random_ops();
      test_bounce();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
